fifo_wptr_full: RTL
===================

# fifo_wptr_full

Write-side pointer and full-flag generator for the async FIFO, in the write clock domain and directly upstream of the FIFO memory. It accepts write requests, drives the memory's write enable and address, and maintains a binary/Gray write pointer. It compares that pointer against the read pointer, which arrives already synchronised into this domain, to produce registered full, almost-full, occupancy and overflow status.

## Interface
- `addr_width`, 3: memory address width; depth = 2^addr_width; pointers are addr_width+1 bits.
- `af_thresh`, 6: walmost_full asserts when wcount >= af_thresh. Legal range 1..2^addr_width.

Ports:
- `wclk`  in  1  write clock; the only clock in this block.
- `wrst`  in  1  reset, synchronous, active-high.
- `winc`  in  1  write request; the word on the memory's wdata is written this cycle if not full.
- `wq2_rptr`  in  addr_width+1  Gray read pointer, already 2-flop synchronised into wclk.
- `wclken`  out  1  memory write enable, combinational: winc & ~wfull.
- `waddr`  out  addr_width  memory write address, equal to wbin[addr_width-1:0].
- `wptr`  out  addr_width+1  registered Gray write pointer, sent to the read-side synchroniser.
- `wfull`  out  1  registered full flag.
- `walmost_full`  out  1  registered almost-full flag.
- `wcount`  out  addr_width+1  registered occupancy as seen by the writer (pessimistic).
- `woverflow`  out  1  sticky flag: winc was asserted while wfull=1.

## Operation
- State: wbin (addr_width+1 binary), wptr (Gray), wfull, walmost_full, wcount, woverflow. All registers.
- winc_ok = winc & ~wfull; wbin_next = wbin + winc_ok, wrapping modulo 2^(addr_width+1).
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- Full test: wfull_next = (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
- rbin_s = gray2bin(wq2_rptr); wcount_next = (wbin_next - rbin_s) mod 2^(addr_width+1), range 0..2^addr_width.
- walmost_full_next = (wcount_next >= af_thresh).
- woverflow is set by winc & wfull and is cleared only by wrst.
- A write attempt while full is dropped: wclken=0, and no pointer, address or count change.
- Release from full happens only when wq2_rptr advances. It is never speculative.

## Timing
- Reset (wrst=1 at a wclk edge): wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wcount=0, woverflow=0. wclken=0 for the whole cycle (winc is masked while wrst=1). Reset mid-operation, including while full, discards all state at the next edge.
- wclken follows winc in the same cycle. The memory captures data at the same edge that advances wbin, waddr and wptr.
- wfull, walmost_full and wcount update at the same edge as the write that changes them. The write that fills the FIFO sees wfull=1 from the next cycle, so there is zero overflow slack.
- Read-side progress appears 2 wclk after a rptr change (external synchroniser), then 1 more edge to reach wfull/wcount.
- Simultaneous write and wq2_rptr advance: both are applied in the same _next computation, so the count is net.
- Wrap-around: wbin goes from 2^(addr_width+1)-1 to 0. The Gray MSB toggles, and full detection stays correct across the wrap.
- wptr changes by exactly one bit per edge. It is never combinational.

## Structure
- Shared package `fifo_pkg`: bin2gray and gray2bin functions, and a pointer-width constant (addr_width+1). These are shared with the read-pointer/empty block.
- No sub-module needed. Synchronisers (wq2_rptr) live outside this block.

## Test plan
All scenarios use addr_width=3 and af_thresh=6.
- Reset, wq2_rptr=0, winc=1 for 8 cycles:
  - waddr runs 0..7 and wclken=1 each cycle.
  - wptr runs 1,3,2,6,7,5,4,12.
  - walmost_full rises after the 6th write.
  - After the 8th write: wfull=1, wcount=8.
- FIFO full, winc=1 for 1 cycle:
  - wclken=0; waddr stays 0 and wptr stays 12.
  - woverflow=1 and stays 1 until reset.
- Set wq2_rptr=4'b0001 (one word read):
  - Next edge: wfull=0, wcount=7.
  - Then winc=1 for 1 cycle: write at waddr 0, wptr=13, wfull=1, wcount=8.
- Pointer wrap, read side tracking 2 behind:
  - After 16 total writes wbin wraps from 15 to 0.
  - wptr goes 8 -> 0, wfull stays 0 and wcount stays 2.
- Simultaneous winc and wq2_rptr advance at wcount=5: wcount stays 5 and walmost_full stays 0.
- wrst pulsed while wfull=1 and winc=1:
  - wclken=0 that cycle.
  - Next edge: every output is 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Pointer helpers and default widths shared by the async FIFO's write-pointer and read-pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;

  // The helpers work on a 32-bit container so any pointer width up to 32 can share them.
  // Callers zero-extend their pointer and slice the result back down.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/almost-full/occupancy/overflow status for the async FIFO (write clock domain).
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int addr_width = FIFO_ADDR_W,
  parameter int af_thresh  = 6
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [addr_width:0]   wq2_rptr,
  output logic                  wclken,
  output logic [addr_width-1:0] waddr,
  output logic [addr_width:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [addr_width:0]   wcount,
  output logic                  woverflow
);

  localparam int PW = addr_width + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wcount_q, wcount_d;
  logic          wfull_q, wfull_d;
  logic          waf_q, waf_d;
  logic          wovf_q, wovf_d;
  logic          winc_ok;
  logic [PW-1:0] rbin_s, full_cmp;
  logic [31:0]   gray_w, rbin_w;

  always_comb begin
    // Writes are masked during reset so the memory never sees a stray enable.
    winc_ok  = winc & ~wfull_q & ~wrst;
    wbin_d   = wbin_q + PW'(winc_ok);
    gray_w   = bin2gray(32'(wbin_d));
    wptr_d   = gray_w[PW-1:0];
    rbin_w   = gray2bin(32'(wq2_rptr));
    rbin_s   = rbin_w[PW-1:0];
    // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    full_cmp = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    wfull_d  = (wptr_d == full_cmp);
    wcount_d = wbin_d - rbin_s;
    waf_d    = (int'(wcount_d) >= af_thresh);
    wovf_d   = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wcount_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wcount_q <= wcount_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wclken       = winc_ok;
  assign waddr        = wbin_q[addr_width-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = waf_q;
  assign wcount       = wcount_q;
  assign woverflow    = wovf_q;

endmodule
